// File: rtl/zap_mem_pkg.sv
// Shared definitions for the ZAP memory stage: magic-number bit positions, FSM states,
// interrupt vector layout, bus request bundle and byte-lane helpers.
package zap_mem_pkg;

  localparam int MAGIC_LOAD      = 8;
  localparam int MAGIC_STORE     = 7;
  localparam int MAGIC_PRE       = 6;
  localparam int MAGIC_UBYTE     = 5;
  localparam int MAGIC_SBYTE     = 4;
  localparam int MAGIC_SHALF     = 3;
  localparam int MAGIC_UHALF     = 2;
  localparam int MAGIC_TRANSLATE = 1;
  localparam int MAGIC_LOCK      = 0;

  localparam int INTR_DABT = 4;
  localparam int INTR_IRQ  = 3;
  localparam int INTR_FIQ  = 2;
  localparam int INTR_IABT = 1;
  localparam int INTR_SWI  = 0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic        stb;
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  ben;
    logic [31:0] wdata;
    logic        lock;
    logic        user;
  } bus_req_t;

  function automatic logic [4:0] intr_vec5(input logic dabt, input logic [3:0] v);
    logic [4:0] r;
    r            = '0;
    r[INTR_DABT] = dabt;
    r[INTR_IRQ]  = v[3];
    r[INTR_FIQ]  = v[2];
    r[INTR_IABT] = v[1];
    r[INTR_SWI]  = v[0];
    return r;
  endfunction

  function automatic logic [3:0] lane_ben(input logic is_byte, input logic is_half,
                                          input logic [1:0] a);
    if (is_byte)      return 4'b0001 << a;
    else if (is_half) return 4'b0011 << {a[1], 1'b0};
    else              return 4'b1111;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic is_byte, input logic is_half,
                                             input logic [31:0] d);
    if (is_byte)      return {4{d[7:0]}};
    else if (is_half) return {2{d[15:0]}};
    else              return d;
  endfunction

endpackage

// File: rtl/zap_load_align.sv
// Combinational load-data aligner: byte/half lane select with zero/sign extension;
// word loads rotate right by 8*addr[1:0] only when ZAP_LOAD_ROTATE_EN is defined.
module zap_load_align (
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_ubyte,
  input  logic        i_sbyte,
  input  logic        i_uhalf,
  input  logic        i_shalf,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_word;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
  end

  assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

`ifdef ZAP_LOAD_ROTATE_EN
  logic [4:0] w_rot_amt;
  assign w_rot_amt = {i_addr_lo, 3'b000};
  assign w_word    = (i_rdata >> w_rot_amt) | (i_rdata << (6'd32 - {1'b0, w_rot_amt}));
`else
  assign w_word = i_rdata;
`endif

  always_comb begin
    o_data = w_word;
    if (i_ubyte)      o_data = {24'd0, w_byte};
    else if (i_sbyte) o_data = {{24{w_byte[7]}}, w_byte};
    else if (i_uhalf) o_data = {16'd0, w_half};
    else if (i_shalf) o_data = {{16{w_half[15]}}, w_half};
  end

endmodule

// File: rtl/zap_memory_stage.sv
// zap_memory_stage: ALU->writeback data-memory stage; ZAP_LOAD_ROTATE_EN rotates misaligned word loads.
// Latency 1 cycle for non-memory ops, 2+ for loads/stores; o_data_stall holds upstream until i_data_ack.
module zap_memory_stage
  import zap_mem_pkg::*;
#(
  parameter int PHY_REGS = 46
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clear_from_writeback,
  input  logic                        i_dav_ff,
  input  logic [31:0]                 i_alu_result_ff,
  input  logic [31:0]                 i_mem_address_ff,
  input  logic [31:0]                 i_mem_srcdest_value_ff,
  input  logic [8:0]                  i_mem_magic_number_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_destination_index_ff,
  input  logic [$clog2(PHY_REGS)-1:0] i_mem_srcdest_index_ff,
  input  logic [31:0]                 i_pc_plus_8_ff,
  input  logic [3:0]                  i_interrupt_vector_ff,
  output logic                        o_data_stall,
  output logic                        o_data_stb,
  output logic                        o_data_wen,
  output logic [31:0]                 o_data_addr,
  output logic [3:0]                  o_data_ben,
  output logic [31:0]                 o_data_wdata,
  output logic                        o_data_lock,
  output logic                        o_data_user,
  input  logic                        i_data_ack,
  input  logic [31:0]                 i_data_rdata,
  input  logic                        i_data_abort,
  output logic                        o_dav_ff,
  output logic                        o_mem_load_ff,
  output logic [31:0]                 o_alu_result_ff,
  output logic [31:0]                 o_mem_load_data_ff,
  output logic [31:0]                 o_pc_plus_8_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_destination_index_ff,
  output logic [$clog2(PHY_REGS)-1:0] o_mem_srcdest_index_ff,
  output logic [4:0]                  o_interrupt_vector_ff
);

  localparam int IDX_W = $clog2(PHY_REGS);

  mem_state_t r_state, w_state_nxt;
  logic       r_kill;
  bus_req_t   r_bus, w_bus_nxt;

  logic w_is_load, w_is_byte, w_is_half, w_mem_op;
  logic w_issue, w_done, w_stall;
  logic w_unused;

  // Instruction context captured at issue so a flushed/advancing upstream cannot corrupt it.
  logic [31:0]      r_pend_result, r_pend_pc;
  logic [IDX_W-1:0] r_pend_dst, r_pend_sd;
  logic [3:0]       r_pend_intr;
  logic             r_pend_load;
  logic [1:0]       r_pend_alo;
  logic             r_pend_ub, r_pend_sb, r_pend_uh, r_pend_sh;

  logic             r_dav, r_load;
  logic [31:0]      r_result, r_ldata, r_pc;
  logic [IDX_W-1:0] r_dst, r_sd;
  logic [4:0]       r_intr;
  logic [31:0]      w_aligned;

  assign w_is_load = i_mem_magic_number_ff[MAGIC_LOAD];
  assign w_is_byte = i_mem_magic_number_ff[MAGIC_UBYTE] | i_mem_magic_number_ff[MAGIC_SBYTE];
  assign w_is_half = i_mem_magic_number_ff[MAGIC_UHALF] | i_mem_magic_number_ff[MAGIC_SHALF];
  assign w_mem_op  = i_dav_ff & (w_is_load | i_mem_magic_number_ff[MAGIC_STORE]);
  assign w_unused  = i_mem_magic_number_ff[MAGIC_PRE];

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_issue     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_mem_op;
        if (w_mem_op && !i_clear_from_writeback) begin
          w_issue     = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_stall = ~i_data_ack;
        if (i_data_ack) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Stall is forced low while reset is held so every output reads zero.
  assign o_data_stall = w_stall & ~i_reset;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_bus_nxt.stb   = 1'b1;
    w_bus_nxt.wen   = ~w_is_load;
    w_bus_nxt.addr  = {i_mem_address_ff[31:2], 2'b00};
    w_bus_nxt.ben   = lane_ben(w_is_byte, w_is_half, i_mem_address_ff[1:0]);
    w_bus_nxt.wdata = lane_wdata(w_is_byte, w_is_half, i_mem_srcdest_value_ff);
    w_bus_nxt.lock  = i_mem_magic_number_ff[MAGIC_LOCK];
    w_bus_nxt.user  = i_mem_magic_number_ff[MAGIC_TRANSLATE];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      r_bus     <= '0;
    else if (w_issue) r_bus     <= w_bus_nxt;
    else if (w_done)  r_bus.stb <= 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                              r_kill <= 1'b0;
    else if (w_done)                                          r_kill <= 1'b0;
    else if (r_state == ST_WAIT && i_clear_from_writeback)    r_kill <= 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pend_result <= '0;
      r_pend_pc     <= '0;
      r_pend_dst    <= '0;
      r_pend_sd     <= '0;
      r_pend_intr   <= '0;
      r_pend_load   <= 1'b0;
      r_pend_alo    <= '0;
      r_pend_ub     <= 1'b0;
      r_pend_sb     <= 1'b0;
      r_pend_uh     <= 1'b0;
      r_pend_sh     <= 1'b0;
    end else if (w_issue) begin
      r_pend_result <= i_alu_result_ff;
      r_pend_pc     <= i_pc_plus_8_ff;
      r_pend_dst    <= i_destination_index_ff;
      r_pend_sd     <= i_mem_srcdest_index_ff;
      r_pend_intr   <= i_interrupt_vector_ff;
      r_pend_load   <= w_is_load;
      r_pend_alo    <= i_mem_address_ff[1:0];
      r_pend_ub     <= i_mem_magic_number_ff[MAGIC_UBYTE];
      r_pend_sb     <= i_mem_magic_number_ff[MAGIC_SBYTE];
      r_pend_uh     <= i_mem_magic_number_ff[MAGIC_UHALF];
      r_pend_sh     <= i_mem_magic_number_ff[MAGIC_SHALF];
    end
  end

  zap_load_align u_align (
    .i_rdata   (i_data_rdata),
    .i_addr_lo (r_pend_alo),
    .i_ubyte   (r_pend_ub),
    .i_sbyte   (r_pend_sb),
    .i_uhalf   (r_pend_uh),
    .i_shalf   (r_pend_sh),
    .o_data    (w_aligned)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dav    <= 1'b0;
      r_load   <= 1'b0;
      r_result <= '0;
      r_ldata  <= '0;
      r_pc     <= '0;
      r_dst    <= '0;
      r_sd     <= '0;
      r_intr   <= '0;
    end else if (r_state == ST_IDLE && !w_issue) begin
      r_dav    <= i_dav_ff & ~i_clear_from_writeback;
      r_load   <= 1'b0;
      r_result <= i_alu_result_ff;
      r_pc     <= i_pc_plus_8_ff;
      r_dst    <= i_destination_index_ff;
      r_sd     <= i_mem_srcdest_index_ff;
      r_intr   <= intr_vec5(1'b0, i_interrupt_vector_ff);
    end else if (w_done) begin
      // A flush seen at any point while waiting, including the ack cycle, kills the result.
      r_dav    <= ~(r_kill | i_clear_from_writeback);
      r_load   <= r_pend_load;
      r_result <= r_pend_result;
      r_ldata  <= w_aligned;
      r_pc     <= r_pend_pc;
      r_dst    <= r_pend_dst;
      r_sd     <= r_pend_sd;
      r_intr   <= intr_vec5(i_data_abort, r_pend_intr);
    end
  end

  assign o_data_stb             = r_bus.stb;
  assign o_data_wen             = r_bus.wen;
  assign o_data_addr            = r_bus.addr;
  assign o_data_ben             = r_bus.ben;
  assign o_data_wdata           = r_bus.wdata;
  assign o_data_lock            = r_bus.lock;
  assign o_data_user            = r_bus.user;
  assign o_dav_ff               = r_dav;
  assign o_mem_load_ff          = r_load;
  assign o_alu_result_ff        = r_result;
  assign o_mem_load_data_ff     = r_ldata;
  assign o_pc_plus_8_ff         = r_pc;
  assign o_destination_index_ff = r_dst;
  assign o_mem_srcdest_index_ff = r_sd;
  assign o_interrupt_vector_ff  = r_intr;

endmodule

// File: tb/tb_zap_memory_stage.sv
// Self-checking bench for zap_memory_stage: directed vector table, hand sequences for
// flush/abort/reset corner cases, and randomized ops against a byte-level reference model.
module tb_zap_memory_stage;

  localparam int PHY_REGS = 46;
  localparam int IW = $clog2(PHY_REGS);

  logic          clk = 1'b0;
  logic          rst;
  logic          clr, dav;
  logic [31:0]   alu_res, maddr, sdval, pc8;
  logic [8:0]    magic;
  logic [IW-1:0] dsti, sdi;
  logic [3:0]    ivec;
  logic          stall, stb, wen, lock, user;
  logic [31:0]   baddr, wdata;
  logic [3:0]    ben;
  logic          ack, abort;
  logic [31:0]   rdata;
  logic          o_dav, o_load;
  logic [31:0]   o_res, o_ldata, o_pc;
  logic [IW-1:0] o_dst, o_sd;
  logic [4:0]    o_ivec;

  always #5 clk = ~clk;

  zap_memory_stage #(.PHY_REGS(PHY_REGS)) dut (
    .i_clk(clk), .i_reset(rst), .i_clear_from_writeback(clr), .i_dav_ff(dav),
    .i_alu_result_ff(alu_res), .i_mem_address_ff(maddr), .i_mem_srcdest_value_ff(sdval),
    .i_mem_magic_number_ff(magic), .i_destination_index_ff(dsti), .i_mem_srcdest_index_ff(sdi),
    .i_pc_plus_8_ff(pc8), .i_interrupt_vector_ff(ivec), .o_data_stall(stall),
    .o_data_stb(stb), .o_data_wen(wen), .o_data_addr(baddr), .o_data_ben(ben),
    .o_data_wdata(wdata), .o_data_lock(lock), .o_data_user(user), .i_data_ack(ack),
    .i_data_rdata(rdata), .i_data_abort(abort), .o_dav_ff(o_dav), .o_mem_load_ff(o_load),
    .o_alu_result_ff(o_res), .o_mem_load_data_ff(o_ldata), .o_pc_plus_8_ff(o_pc),
    .o_destination_index_ff(o_dst), .o_mem_srcdest_index_ff(o_sd),
    .o_interrupt_vector_ff(o_ivec)
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {K_ALU, K_LDR, K_LDRB, K_LDRSB, K_LDRH, K_LDRSH, K_STR, K_STRB, K_STRH} kind_e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic is_load(kind_e k);
    return (k == K_LDR || k == K_LDRB || k == K_LDRSB || k == K_LDRH || k == K_LDRSH);
  endfunction
  function automatic logic is_signed(kind_e k);
    return (k == K_LDRSB || k == K_LDRSH);
  endfunction
  function automatic int size_of(kind_e k);
    case (k)
      K_LDRB, K_LDRSB, K_STRB: return 1;
      K_LDRH, K_LDRSH, K_STRH: return 2;
      default:                 return 4;
    endcase
  endfunction
  function automatic logic [8:0] magic_of(kind_e k, logic lk, logic tr);
    logic [8:0] m;
    m = '0;
    case (k)
      K_LDR:   m[8] = 1'b1;
      K_LDRB:  begin m[8] = 1'b1; m[5] = 1'b1; end
      K_LDRSB: begin m[8] = 1'b1; m[4] = 1'b1; end
      K_LDRH:  begin m[8] = 1'b1; m[2] = 1'b1; end
      K_LDRSH: begin m[8] = 1'b1; m[3] = 1'b1; end
      K_STR:   m[7] = 1'b1;
      K_STRB:  begin m[7] = 1'b1; m[5] = 1'b1; end
      K_STRH:  begin m[7] = 1'b1; m[2] = 1'b1; end
      default: m = '0;
    endcase
    m[1] = tr;
    m[0] = lk;
    return m;
  endfunction
  function automatic logic [3:0] m_ben(kind_e k, logic [31:0] a);
    int sz, off;
    logic [3:0] b;
    sz  = size_of(k);
    off = (int'(a[1:0]) / sz) * sz;
    b   = '0;
    for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) b[i] = 1'b1;
    return b;
  endfunction
  function automatic logic [31:0] m_wdata(kind_e k, logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = size_of(k);
    r  = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] m_ldata(kind_e k, logic [31:0] a, logic [31:0] rd);
    logic [31:0] r;
    int sz, off;
    sz = size_of(k);
    r  = '0;
    if (sz == 4) begin
`ifdef ZAP_LOAD_ROTATE_EN
      for (int i = 0; i < 4; i++) r[8*i +: 8] = rd[8*((i + int'(a[1:0])) % 4) +: 8];
`else
      r = rd;
`endif
      return r;
    end
    off = (int'(a[1:0]) / sz) * sz;
    for (int j = 0; j < sz; j++) r[8*j +: 8] = rd[8*(off + j) +: 8];
    if (is_signed(k) && r[8*sz-1])
      for (int j = sz; j < 4; j++) r[8*j +: 8] = 8'hFF;
    return r;
  endfunction

  // ---------------- stimulus ----------------
  logic [31:0] c_addr, c_wdata, c_ldata;
  logic [3:0]  c_ben;
  int          c_stalls;

  task automatic idle_inputs();
    dav = 1'b0; clr = 1'b0; magic = '0; maddr = '0; sdval = '0;
    ack = 1'b0; abort = 1'b0; rdata = '0;
  endtask

  // Called and returns at a negedge; bus responder acks after 'delay' extra wait cycles.
  task automatic run_op(input kind_e k, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int delay, input logic ab,
                        input logic lk, input logic tr, input logic v,
                        output logic [31:0] ca, output logic [3:0] cb,
                        output logic [31:0] cw, output logic [31:0] cl, output int ns);
    logic [31:0]   e_res, e_pc;
    logic [IW-1:0] e_dst, e_sd;
    logic [3:0]    e_vec;
    logic          mem;
    e_res = $urandom; e_pc = $urandom; e_vec = 4'($urandom);
    e_dst = IW'($urandom_range(0, PHY_REGS-1));
    e_sd  = IW'($urandom_range(0, PHY_REGS-1));
    mem   = v && (k != K_ALU);
    dav = v; clr = 1'b0; magic = magic_of(k, lk, tr); maddr = a; sdval = d;
    alu_res = e_res; pc8 = e_pc; dsti = e_dst; sdi = e_sd; ivec = e_vec;
    ca = '0; cb = '0; cw = '0; cl = '0; ns = 0;
    #1;
    if (!mem) begin
      chk("alu_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      chk("alu_dav", {31'd0, o_dav}, {31'd0, v});
      chk("alu_result", o_res, e_res);
      chk("alu_pc", o_pc, e_pc);
      chk("alu_idx", {o_dst, o_sd}, {e_dst, e_sd});
      chk("alu_ivec", {27'd0, o_ivec}, {28'd0, e_vec});
      return;
    end
    if (stall) ns++;
    @(negedge clk);
    ca = baddr; cb = ben; cw = wdata;
    chk("bus_stb", {31'd0, stb}, 32'd1);
    chk("bus_wen", {31'd0, wen}, {31'd0, !is_load(k)});
    chk("bus_addr", baddr, {a[31:2], 2'b00});
    chk("bus_ben", {28'd0, ben}, {28'd0, m_ben(k, a)});
    if (!is_load(k)) chk("bus_wdata", wdata, m_wdata(k, d));
    chk("bus_lock_user", {30'd0, lock, user}, {30'd0, lk, tr});
    for (int c = 0; c < delay; c++) begin
      ack = 1'b0;
      #1;
      if (stall) ns++;
      chk("stb_held", {31'd0, stb}, 32'd1);
      @(negedge clk);
    end
    ack = 1'b1; rdata = rd; abort = ab;
    #1;
    if (stall) ns++;
    @(negedge clk);
    ack = 1'b0; abort = 1'b0;
    cl = o_ldata;
    chk("stall_cycles", ns, delay + 1);
    chk("stb_dropped", {31'd0, stb}, 32'd0);
    chk("mem_dav", {31'd0, o_dav}, 32'd1);
    chk("mem_load", {31'd0, o_load}, {31'd0, is_load(k)});
    chk("mem_result", o_res, e_res);
    chk("mem_pc_idx", o_pc ^ {20'd0, o_dst, o_sd}, e_pc ^ {20'd0, e_dst, e_sd});
    chk("mem_ivec", {27'd0, o_ivec}, {27'd0, ab, e_vec});
    if (is_load(k)) chk("load_data", o_ldata, m_ldata(k, a, rd));
  endtask

  typedef struct {
    kind_e       k;
    logic [31:0] a, d, rd;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_ben;
    logic [31:0] e_wdata, e_ldata;
    int          e_stalls;
  } vec_t;

  vec_t vt[7];

  initial begin
    rst = 1'b1; alu_res = '0; pc8 = '0; dsti = '0; sdi = '0; ivec = '0;
    idle_inputs();
    #2;
    chk("rst_bus", {stb, wen, lock, user, ben, stall}, '0);
    chk("rst_bus_ad", baddr | wdata, '0);
    chk("rst_wb", {o_dav, o_load, o_dst, o_sd, o_ivec}, '0);
    chk("rst_wb_data", o_res | o_ldata | o_pc, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ADD: result 0x1234 next cycle, no stall
    dav = 1'b1; magic = '0; alu_res = 32'h1234;
    #1 chk("add_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    chk("add_result", o_res, 32'h1234);
    chk("add_dav", {31'd0, o_dav}, 32'd1);

`ifdef ZAP_LOAD_ROTATE_EN
    vt[0] = '{K_LDR,  32'h3001, 32'h0, 32'h44332211, 0, 32'h3000, 4'b1111, 32'h0, 32'h11443322, 1};
`else
    vt[0] = '{K_LDR,  32'h3001, 32'h0, 32'h44332211, 0, 32'h3000, 4'b1111, 32'h0, 32'h44332211, 1};
`endif
    vt[1] = '{K_STRB, 32'h1003, 32'hAB, 32'h0, 3, 32'h1000, 4'b1000, 32'hABABABAB, 32'h0, 4};
    vt[2] = '{K_LDRSH, 32'h2002, 32'h0, 32'h80010000, 1, 32'h2000, 4'b1100, 32'h0, 32'hFFFF8001, 2};
    vt[3] = '{K_LDRH, 32'h2002, 32'h0, 32'h80010000, 0, 32'h2000, 4'b1100, 32'h0, 32'h00008001, 1};
    vt[4] = '{K_LDRSB, 32'h0011, 32'h0, 32'h00008000, 2, 32'h0010, 4'b0010, 32'h0, 32'hFFFFFF80, 3};
    vt[5] = '{K_STRH, 32'h0022, 32'h1234BEEF, 32'h0, 0, 32'h0020, 4'b1100, 32'hBEEFBEEF, 32'h0, 1};
    vt[6] = '{K_STR,  32'h0044, 32'hCAFEF00D, 32'h0, 1, 32'h0044, 4'b1111, 32'hCAFEF00D, 32'h0, 2};

    for (int i = 0; i < 7; i++) begin
      run_op(vt[i].k, vt[i].a, vt[i].d, vt[i].rd, vt[i].delay, 1'b0, 1'b0, 1'b0, 1'b1,
             c_addr, c_ben, c_wdata, c_ldata, c_stalls);
      chk("vec_addr", c_addr, vt[i].e_addr);
      chk("vec_ben", {28'd0, c_ben}, {28'd0, vt[i].e_ben});
      chk("vec_stalls", c_stalls, vt[i].e_stalls);
      if (is_load(vt[i].k)) chk("vec_ldata", c_ldata, vt[i].e_ldata);
      else                  chk("vec_wdata", c_wdata, vt[i].e_wdata);
    end

    // Data abort with ack
    run_op(K_LDR, 32'h500, 32'h0, 32'hDEAD0001, 1, 1'b1, 1'b1, 1'b1, 1'b1,
           c_addr, c_ben, c_wdata, c_ldata, c_stalls);
    chk("abort_dabt", {31'd0, o_ivec[4]}, 32'd1);

    // Flush while waiting: strobe held until ack, result killed
    dav = 1'b1; magic = magic_of(K_LDR, 1'b0, 1'b0); maddr = 32'h100;
    @(negedge clk);
    clr = 1'b1;
    #1 chk("clr_wait_stb0", {31'd0, stb}, 32'd1);
    @(negedge clk);
    clr = 1'b0;
    #1 chk("clr_wait_stb1", {31'd0, stb}, 32'd1);
    @(negedge clk);
    chk("clr_wait_stb2", {31'd0, stb}, 32'd1);
    ack = 1'b1; rdata = 32'h12345678;
    @(negedge clk);
    ack = 1'b0; dav = 1'b0;
    chk("clr_wait_dav", {31'd0, o_dav}, 32'd0);
    chk("clr_wait_stb_off", {31'd0, stb}, 32'd0);

    // Flush in IDLE beats a new memory op
    run_op(K_ALU, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1,
           c_addr, c_ben, c_wdata, c_ldata, c_stalls);
    dav = 1'b1; clr = 1'b1; magic = magic_of(K_STR, 1'b0, 1'b0); maddr = 32'h200;
    @(negedge clk);
    dav = 1'b0; clr = 1'b0;
    chk("clr_idle_stb", {31'd0, stb}, 32'd0);
    chk("clr_idle_dav", {31'd0, o_dav}, 32'd0);
    @(negedge clk);
    chk("clr_idle_no_req", {31'd0, stb}, 32'd0);

    // Async reset in WAIT clears everything immediately
    run_op(K_ALU, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1,
           c_addr, c_ben, c_wdata, c_ldata, c_stalls);
    dav = 1'b1; magic = magic_of(K_STRB, 1'b1, 1'b1); maddr = 32'hFFF3; sdval = 32'h5A;
    @(negedge clk);
    chk("rstw_pre_stb", {31'd0, stb}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rstw_bus", {stb, wen, lock, user, ben, stall}, '0);
    chk("rstw_bus_ad", baddr | wdata, '0);
    chk("rstw_wb", {o_dav, o_load, o_dst, o_sd, o_ivec}, '0);
    chk("rstw_wb_data", o_res | o_ldata | o_pc, '0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);

    // Randomized mix against the reference model
    for (int i = 0; i < 80; i++) begin
      kind_e k;
      logic  v;
      k = kind_e'($urandom_range(0, 8));
      v = (k != K_ALU) ? 1'b1 : 1'($urandom);
      run_op(k, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom), v,
             c_addr, c_ben, c_wdata, c_ldata, c_stalls);
    end

    idle_inputs();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
